// File: rtl/insn_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack port and hands them
// to the decoders over valid/ready, then follows the decoded next-PC decision.
module insn_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] INSN,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] PC,
    input  logic        pc_next_sel,
    input  logic [31:0] pc_target,
    output logic        fetch_fault,
    output logic [1:0]  dbg_state
);

    // Handshakes: memory side holds mem_req/mem_addr until mem_ack is seen in WAIT;
    // decoder side transfers INSN when insn_valid & insn_ready at a rising edge.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insn_q, insn_d;
    logic        mem_req_q, mem_req_d;
    logic        insn_valid_q, insn_valid_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic        accept;
    logic [31:0] next_pc;

    assign accept  = insn_valid_q & insn_ready;
    assign next_pc = pc_next_sel ? (pc_target & ~32'h1) : (pc_q + 32'd4);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        insn_d        = insn_q;
        mem_req_d     = mem_req_q;
        insn_valid_d  = insn_valid_q;
        fetch_fault_d = fetch_fault_q;
        case (state_q)
            S_FETCH: begin
                state_d   = S_WAIT;
                mem_req_d = 1'b1;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d      = S_HOLD;
                    insn_d       = mem_rdata;
                    insn_valid_d = 1'b1;
                    mem_req_d    = 1'b0;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    pc_d         = next_pc;
                    insn_d       = NOP_INSN;
                    insn_valid_d = 1'b0;
                    // Bit 0 is always cleared, so only bit 1 can make a target misaligned.
                    if (next_pc[1]) begin
                        state_d       = S_FAULT;
                        fetch_fault_d = 1'b1;
                        mem_req_d     = 1'b0;
                    end else begin
                        state_d   = S_FETCH;
                        mem_req_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            insn_q        <= NOP_INSN;
            mem_req_q     <= 1'b0;
            insn_valid_q  <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            insn_q        <= insn_d;
            mem_req_q     <= mem_req_d;
            insn_valid_q  <= insn_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign INSN        = insn_q;
    assign insn_valid  = insn_valid_q;
    assign PC          = pc_q;
    assign fetch_fault = fetch_fault_q;
    assign dbg_state   = state_q;

endmodule
